interrupt_sequencer: RTL and testbench
======================================

INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer flops per irq_src line; legal range 2..4.
REQ-002 Parameter ACK_TIMEOUT, default 64: cycles in REQ without ack before the request is abandoned; legal range 2..255.
REQ-003 Port clk, input, 1: single clock; all state updates on posedge.
REQ-004 Port rst, input, 1: synchronous, active-low reset, sampled on posedge clk.
REQ-005 Port irq_src, input, 6: raw asynchronous interrupt lines, rising-edge significant.
REQ-006 Port im, input, 6: mask from CP0 Status[15:10]; 1 = enabled.
REQ-007 Port ie, input, 1: global enable from CP0 Status[0].
REQ-008 Port exl, input, 1: CP0 EXL flag; 1 = exception in progress.
REQ-009 Port ack, input, 1: one-cycle pulse, CPU has taken the interrupt.
REQ-010 Port eoi, input, 1: one-cycle pulse, ERET retired.
REQ-011 Port clr_err, input, 1: clears timeout_err.
REQ-012 Port int_out, output, 6: registered one-hot request to the CP0 interrupt port.
REQ-013 Port irq_id, output, 3: index of the line in REQ or SERVICE; 3'd7 when IDLE.
REQ-014 Port busy, output, 1: high in REQ or SERVICE.
REQ-015 Port pending, output, 6: pending register, visible for debug.
REQ-016 Port timeout_err, output, 1: sticky ack-timeout flag.

Function
REQ-017 Each irq_src bit SHALL pass through SYNC_STAGES flops, then a registered rising-edge detector; a detected edge SHALL set pending[i] on the next posedge.
REQ-018 A line is eligible when pending[i] & im[i] & ie & ~exl; masked pending bits SHALL be retained, not dropped.
REQ-019 Priority is fixed: the highest eligible index wins (bit 5 highest).
REQ-020 FSM states are IDLE, REQ, SERVICE.
REQ-021 IDLE->REQ SHALL occur on the posedge where any line is eligible; int_out SHALL become the winner's one-hot on that same edge and irq_id SHALL latch the winner's index.
REQ-022 Latency: from a rising irq_src edge sampled on edge k, int_out SHALL be high after edge k+SYNC_STAGES+1 when the line is eligible and the FSM is IDLE.
REQ-023 REQ->SERVICE on ack: int_out SHALL clear, pending[irq_id] SHALL clear, and irq_id SHALL hold.
REQ-024 REQ->IDLE without ack SHALL occur when the selected line becomes ineligible (im, ie or exl change): int_out SHALL clear, pending SHALL be kept, and the timeout counter SHALL reset.
REQ-025 REQ->IDLE SHALL occur when the timeout counter reaches ACK_TIMEOUT: int_out SHALL clear, pending SHALL be kept, and timeout_err SHALL set.
REQ-026 The timeout counter SHALL be zeroed on REQ entry and increment once per REQ cycle; it saturates, it never wraps.
REQ-027 SERVICE->IDLE on eoi; no nesting is supported, and higher-priority edges SHALL accumulate in pending during SERVICE.
REQ-028 ack outside REQ and eoi outside SERVICE SHALL be ignored.
REQ-029 A new edge on line i coinciding with the clear of pending[i] SHALL leave pending[i] set (set wins).
REQ-030 The winner SHALL be re-evaluated only in IDLE; a higher-priority edge during REQ SHALL NOT preempt the current request.
REQ-031 clr_err coinciding with a timeout SHALL leave timeout_err set (set wins).

Reset
REQ-032 With rst low at posedge: FSM=IDLE, int_out=0, irq_id=7, busy=0, pending=0, timeout_err=0, timeout counter=0, all synchronizer and edge-detect flops=0.
REQ-033 Reset asserted mid-REQ or mid-SERVICE SHALL abandon the transaction with no residual pending state.
REQ-034 A line held high through reset release SHALL register as a rising edge once its synchronizer fills.

Structure
REQ-035 Shared package cp0_pkg SHALL hold the FSM state enum, IRQ_W=6, ID_W=3 and IRQ_ID_NONE=3'd7.
REQ-036 One sub-module sync_edge (synchronizer plus rising-edge detector, 1 bit, parameter SYNC_STAGES) SHALL be instantiated six times.

Verification
REQ-037 Basic flow: ie=1, im=6'h3F, irq_src[2] rises -> int_out=6'h04 after SYNC_STAGES+1 edges, irq_id=2; ack -> int_out=0, pending[2]=0, busy=1; eoi -> busy=0, irq_id=7.
REQ-038 Priority: irq_src[1] and irq_src[4] rise together -> int_out=6'h10; after ack and eoi -> int_out=6'h02.
REQ-039 Masking: im=6'h00, irq_src[3] rises -> pending=6'h08, int_out=0; set im[3]=1 -> int_out=6'h08 the next edge.
REQ-040 Timeout: eligible request, ack withheld for 64 cycles -> int_out=0, timeout_err=1, pending bit still set; clr_err -> timeout_err=0, request re-issued.
REQ-041 EXL and reset: exl rises during REQ -> IDLE next edge, pending kept; separately, rst low during SERVICE -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/cp0_pkg.sv
// ---------------------------------------------------------------------------
// cp0_pkg
// Shared definitions for the CP0 interrupt sequencer: sequencer state
// encoding, interrupt line / index widths, the "no line" index value and
// a fixed-priority selection helper.
// ---------------------------------------------------------------------------
package cp0_pkg;

    localparam int IRQ_W = 6;
    localparam int ID_W  = 3;

    localparam logic [ID_W-1:0] IRQ_ID_NONE = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    // Index of the highest set bit; IRQ_ID_NONE when no bit is set.
    function automatic logic [ID_W-1:0] highest_idx(input logic [IRQ_W-1:0] v);
        logic [ID_W-1:0] r;
        r = IRQ_ID_NONE;
        for (int i = 0; i < IRQ_W; i++) begin
            if (v[i]) begin
                r = ID_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// ---------------------------------------------------------------------------
// sync_edge
// One-bit multi-flop synchronizer followed by a registered rising-edge
// detector. rise is a one-cycle pulse, registered.
// Ports:
//   clk  - clock
//   rst  - synchronous active-low reset
//   din  - raw asynchronous input
//   rise - registered one-cycle pulse on a synchronized 0->1 transition
// ---------------------------------------------------------------------------
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;
    logic                   rise_r;

    // Synchronizer chain, previous-value flop and registered edge pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            prev_r <= 1'b0;
            rise_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], din};
            prev_r <= sync_r[SYNC_STAGES-1];
            rise_r <= sync_r[SYNC_STAGES-1] & ~prev_r;
        end
    end

    assign rise = rise_r;

endmodule

// File: rtl/interrupt_sequencer.sv
// ---------------------------------------------------------------------------
// interrupt_sequencer
// Collects rising edges on six asynchronous interrupt lines into a pending
// register and presents the highest-priority eligible line to CP0 as a
// one-hot request, then tracks the ack / ERET handshake.
// Ports:
//   clk, rst     - clock, synchronous active-low reset
//   irq_src[5:0] - raw asynchronous interrupt lines (rising edge significant)
//   im[5:0], ie  - per-line mask and global enable (1 = enabled)
//   exl          - exception in progress, blocks new requests
//   ack          - CPU took the interrupt (honoured only while requesting)
//   eoi          - ERET retired (honoured only while in service)
//   clr_err      - clears the sticky timeout flag
//   int_out[5:0] - registered one-hot request
//   irq_id[2:0]  - line being requested / serviced, 7 when idle
//   busy         - request or service in progress
//   pending[5:0] - pending edges (debug)
//   timeout_err  - sticky: a request was abandoned for lack of ack
// ---------------------------------------------------------------------------
module interrupt_sequencer
    import cp0_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IRQ_W-1:0] irq_src,
    input  logic [IRQ_W-1:0] im,
    input  logic             ie,
    input  logic             exl,
    input  logic             ack,
    input  logic             eoi,
    input  logic             clr_err,
    output logic [IRQ_W-1:0] int_out,
    output logic [ID_W-1:0]  irq_id,
    output logic             busy,
    output logic [IRQ_W-1:0] pending,
    output logic             timeout_err
);

    // Last REQ cycle value of the counter: leaving on it gives ACK_TIMEOUT
    // cycles of asserted request.
    localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

    logic [IRQ_W-1:0] edge_s;
    logic [IRQ_W-1:0] view_s;
    logic [IRQ_W-1:0] elig_s;
    logic [IRQ_W-1:0] clr_mask_s;
    logic [IRQ_W-1:0] pending_s;
    logic [IRQ_W-1:0] int_out_s;
    logic [ID_W-1:0]  win_s;
    logic [ID_W-1:0]  irq_id_s;
    logic [7:0]       cnt_s;
    logic             err_set_s;
    logic             err_s;
    state_e           state_s;

    logic [IRQ_W-1:0] pending_r;
    logic [IRQ_W-1:0] int_out_r;
    logic [ID_W-1:0]  irq_id_r;
    logic [7:0]       cnt_r;
    logic             busy_r;
    logic             err_r;
    state_e           state_r;

    for (genvar g = 0; g < IRQ_W; g++) begin : g_sync
        sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync_edge (
            .clk  (clk),
            .rst  (rst),
            .din  (irq_src[g]),
            .rise (edge_s[g])
        );
    end

    // An edge arriving this cycle already counts, so a fresh edge can be
    // requested on the same posedge that records it in pending.
    assign view_s = pending_r | edge_s;
    assign elig_s = view_s & im & {IRQ_W{ie & ~exl}};
    assign win_s  = highest_idx(elig_s);

    // Sequencer next-state, request outputs, pending clear and error update.
    always_comb begin
        state_s    = state_r;
        int_out_s  = int_out_r;
        irq_id_s   = irq_id_r;
        cnt_s      = cnt_r;
        clr_mask_s = {IRQ_W{1'b0}};
        err_set_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|elig_s) begin
                    state_s   = ST_REQ;
                    int_out_s = IRQ_W'(1'b1) << win_s;
                    irq_id_s  = win_s;
                    cnt_s     = 8'd0;
                end else begin
                    int_out_s = {IRQ_W{1'b0}};
                    irq_id_s  = IRQ_ID_NONE;
                end
            end
            ST_REQ: begin
                if (ack) begin
                    state_s    = ST_SERVICE;
                    int_out_s  = {IRQ_W{1'b0}};
                    clr_mask_s = IRQ_W'(1'b1) << irq_id_r;
                end else if (!elig_s[irq_id_r]) begin
                    state_s   = ST_IDLE;
                    int_out_s = {IRQ_W{1'b0}};
                    irq_id_s  = IRQ_ID_NONE;
                    cnt_s     = 8'd0;
                end else if (cnt_r >= TO_LAST) begin
                    state_s   = ST_IDLE;
                    int_out_s = {IRQ_W{1'b0}};
                    irq_id_s  = IRQ_ID_NONE;
                    err_set_s = 1'b1;
                end else begin
                    cnt_s = (cnt_r == 8'hFF) ? cnt_r : cnt_r + 8'd1;
                end
            end
            ST_SERVICE: begin
                if (eoi) begin
                    state_s  = ST_IDLE;
                    irq_id_s = IRQ_ID_NONE;
                end else begin
                    state_s = ST_SERVICE;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                int_out_s = {IRQ_W{1'b0}};
                irq_id_s  = IRQ_ID_NONE;
                cnt_s     = 8'd0;
            end
        endcase

        // A new edge wins over the clear of the same bit.
        pending_s = (pending_r & ~clr_mask_s) | edge_s;

        // A timeout wins over a simultaneous clear request.
        if (err_set_s) begin
            err_s = 1'b1;
        end else if (clr_err) begin
            err_s = 1'b0;
        end else begin
            err_s = err_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            int_out_r <= {IRQ_W{1'b0}};
            irq_id_r  <= IRQ_ID_NONE;
            cnt_r     <= 8'd0;
            busy_r    <= 1'b0;
            err_r     <= 1'b0;
            pending_r <= {IRQ_W{1'b0}};
        end else begin
            state_r   <= state_s;
            int_out_r <= int_out_s;
            irq_id_r  <= irq_id_s;
            cnt_r     <= cnt_s;
            busy_r    <= (state_s != ST_IDLE);
            err_r     <= err_s;
            pending_r <= pending_s;
        end
    end

    assign int_out     = int_out_r;
    assign irq_id      = irq_id_r;
    assign busy        = busy_r;
    assign pending     = pending_r;
    assign timeout_err = err_r;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// ---------------------------------------------------------------------------
// tb_interrupt_sequencer
// Directed scenarios plus a randomized run compared against a behavioural
// model of the sequencer kept in this bench.
// ---------------------------------------------------------------------------
module tb_interrupt_sequencer;

    localparam int S  = 2;
    localparam int TO = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] irq_src = 6'h00;
    logic [5:0] im = 6'h00;
    logic       ie = 1'b0;
    logic       exl = 1'b0;
    logic       ack = 1'b0;
    logic       eoi = 1'b0;
    logic       clr_err = 1'b0;
    logic [5:0] int_out;
    logic [2:0] irq_id;
    logic       busy;
    logic [5:0] pending;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    // Reference model state: sampled-line history, pending set, the line
    // being handled (-1 = none), whether it is in service, request age.
    logic [5:0] hist [0:7];
    logic [5:0] m_pend = 6'h00;
    int         m_cur = -1;
    bit         m_svc = 1'b0;
    int         m_age = 0;
    bit         m_err = 1'b0;

    interrupt_sequencer #(
        .SYNC_STAGES(S),
        .ACK_TIMEOUT(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .irq_src     (irq_src),
        .im          (im),
        .ie          (ie),
        .exl         (exl),
        .ack         (ack),
        .eoi         (eoi),
        .clr_err     (clr_err),
        .int_out     (int_out),
        .irq_id      (irq_id),
        .busy        (busy),
        .pending     (pending),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    function automatic int top_bit(input logic [5:0] v);
        int r = -1;
        for (int i = 0; i < 6; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic logic [5:0] m_int_out();
        logic [5:0] one = 6'b000001;
        return (m_cur >= 0 && !m_svc) ? (one << m_cur) : 6'h00;
    endfunction

    function automatic logic [2:0] m_irq_id();
        return (m_cur < 0) ? 3'd7 : 3'(m_cur);
    endfunction

    // Advance one clock edge, update the model from the inputs seen at that
    // edge, then settle 1 time unit past the edge.
    task automatic tick();
        logic [5:0] edges, elig, clr;
        bit         to;
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 8; i++) hist[i] = 6'h00;
            m_pend = 6'h00; m_cur = -1; m_svc = 1'b0; m_age = 0; m_err = 1'b0;
        end else begin
            // A line sampled high S+1 edges ago after being low S+2 edges ago
            // becomes pending now.
            edges = hist[S] & ~hist[S+1];
            elig  = (ie && !exl) ? ((m_pend | edges) & im) : 6'h00;
            clr   = 6'h00;
            to    = 1'b0;
            if (m_cur < 0) begin
                if (elig != 6'h00) begin
                    m_cur = top_bit(elig);
                    m_age = 0;
                end
            end else if (!m_svc) begin
                if (ack) begin
                    m_svc = 1'b1;
                    clr[m_cur] = 1'b1;
                end else if (!elig[m_cur]) begin
                    m_cur = -1;
                end else if (m_age + 1 >= TO) begin
                    m_cur = -1;
                    to = 1'b1;
                end else begin
                    m_age++;
                end
            end else if (eoi) begin
                m_svc = 1'b0;
                m_cur = -1;
            end
            if (to) m_err = 1'b1;
            else if (clr_err) m_err = 1'b0;
            m_pend = (m_pend & ~clr) | edges;
            for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = irq_src;
        end
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0; irq_src = 6'h00; im = 6'h3F; ie = 1'b1; exl = 1'b0;
        ack = 1'b0; eoi = 1'b0; clr_err = 1'b0;
        tick(); tick();
        rst = 1'b1;
        for (int i = 0; i < S + 3; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; irq_src = 6'h02; im = 6'h3F; ie = 1'b1; exl = 1'b0;
        ack = 1'b0; eoi = 1'b0; clr_err = 1'b0;
        tick(); tick();
        checks++;
        if (int_out !== 6'h00 || irq_id !== 3'd7 || busy !== 1'b0 || pending !== 6'h00 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got int_out=%h id=%0d busy=%b pend=%h err=%b, want 00/7/0/00/0",
                     int_out, irq_id, busy, pending, timeout_err);
        end
        rst = 1'b1;
        for (int i = 0; i < S + 1; i++) tick();
        checks++;
        if (int_out !== 6'h00) begin
            errors++; $display("FAIL held_line_early: got int_out=%h, want 00", int_out);
        end
        tick();
        checks++;
        if (int_out !== 6'h02 || irq_id !== 3'd1) begin
            errors++; $display("FAIL held_line_edge: got int_out=%h id=%0d, want 02/1", int_out, irq_id);
        end
    endtask

    task automatic test_basic();
        apply_reset();
        irq_src = 6'h04;
        for (int i = 0; i < S + 1; i++) tick();
        checks++;
        if (int_out !== 6'h00) begin
            errors++; $display("FAIL basic_latency_early: got int_out=%h, want 00", int_out);
        end
        tick();
        checks++;
        if (int_out !== 6'h04 || irq_id !== 3'd2 || busy !== 1'b1) begin
            errors++; $display("FAIL basic_request: got int_out=%h id=%0d busy=%b, want 04/2/1", int_out, irq_id, busy);
        end
        ack = 1'b1; tick(); ack = 1'b0;
        checks++;
        if (int_out !== 6'h00 || pending[2] !== 1'b0 || busy !== 1'b1 || irq_id !== 3'd2) begin
            errors++; $display("FAIL basic_ack: got int_out=%h pend=%h busy=%b id=%0d, want 00/pend[2]=0/1/2",
                               int_out, pending, busy, irq_id);
        end
        eoi = 1'b1; tick(); eoi = 1'b0;
        checks++;
        if (busy !== 1'b0 || irq_id !== 3'd7) begin
            errors++; $display("FAIL basic_eoi: got busy=%b id=%0d, want 0/7", busy, irq_id);
        end
    endtask

    task automatic test_priority();
        apply_reset();
        irq_src = 6'h12;
        for (int i = 0; i < S + 2; i++) tick();
        checks++;
        if (int_out !== 6'h10 || irq_id !== 3'd4) begin
            errors++; $display("FAIL priority_first: got int_out=%h id=%0d, want 10/4", int_out, irq_id);
        end
        ack = 1'b1; tick(); ack = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;
        tick();
        checks++;
        if (int_out !== 6'h02 || irq_id !== 3'd1) begin
            errors++; $display("FAIL priority_second: got int_out=%h id=%0d, want 02/1", int_out, irq_id);
        end
    endtask

    task automatic test_masking();
        apply_reset();
        im = 6'h00;
        irq_src = 6'h08;
        for (int i = 0; i < S + 4; i++) tick();
        checks++;
        if (pending !== 6'h08 || int_out !== 6'h00) begin
            errors++; $display("FAIL masked_retained: got pend=%h int_out=%h, want 08/00", pending, int_out);
        end
        im = 6'h08;
        tick();
        checks++;
        if (int_out !== 6'h08) begin
            errors++; $display("FAIL unmask_request: got int_out=%h, want 08", int_out);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        irq_src = 6'h01;
        for (int i = 0; i < S + 2; i++) tick();
        for (int i = 0; i < TO - 1; i++) tick();
        checks++;
        if (int_out !== 6'h01 || timeout_err !== 1'b0) begin
            errors++; $display("FAIL timeout_early: got int_out=%h err=%b, want 01/0", int_out, timeout_err);
        end
        // clr_err on the timeout edge itself: the timeout must win.
        clr_err = 1'b1;
        tick();
        checks++;
        if (int_out !== 6'h00 || timeout_err !== 1'b1 || pending[0] !== 1'b1) begin
            errors++; $display("FAIL timeout_hit: got int_out=%h err=%b pend=%h, want 00/1/pend[0]=1",
                               int_out, timeout_err, pending);
        end
        tick();
        clr_err = 1'b0;
        checks++;
        if (timeout_err !== 1'b0 || int_out !== 6'h01) begin
            errors++; $display("FAIL timeout_clear_reissue: got err=%b int_out=%h, want 0/01", timeout_err, int_out);
        end
    endtask

    task automatic test_exl_reset();
        apply_reset();
        irq_src = 6'h20;
        for (int i = 0; i < S + 2; i++) tick();
        exl = 1'b1; tick();
        checks++;
        if (int_out !== 6'h00 || busy !== 1'b0 || pending !== 6'h20 || irq_id !== 3'd7) begin
            errors++; $display("FAIL exl_abandon: got int_out=%h busy=%b pend=%h id=%0d, want 00/0/20/7",
                               int_out, busy, pending, irq_id);
        end
        exl = 1'b0; tick();
        checks++;
        if (int_out !== 6'h20) begin
            errors++; $display("FAIL exl_reissue: got int_out=%h, want 20", int_out);
        end
        ack = 1'b1; tick(); ack = 1'b0;
        rst = 1'b0; tick(); rst = 1'b1;
        checks++;
        if (int_out !== 6'h00 || irq_id !== 3'd7 || busy !== 1'b0 || pending !== 6'h00 || timeout_err !== 1'b0) begin
            errors++; $display("FAIL reset_in_service: got int_out=%h id=%0d busy=%b pend=%h err=%b, want 00/7/0/00/0",
                               int_out, irq_id, busy, pending, timeout_err);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        irq_src = 6'h04;
        for (int i = 0; i < S + 2; i++) tick();
        irq_src = 6'h00; tick();
        irq_src = 6'h04;
        for (int i = 0; i < S + 1; i++) tick();
        // ack lands on the edge that records the second rising edge.
        ack = 1'b1; tick(); ack = 1'b0;
        checks++;
        if (busy !== 1'b1 || int_out !== 6'h00 || pending[2] !== 1'b1) begin
            errors++; $display("FAIL set_wins_clear: got busy=%b int_out=%h pend=%h, want 1/00/pend[2]=1",
                               busy, int_out, pending);
        end
        eoi = 1'b1; tick(); eoi = 1'b0;
        tick();
        checks++;
        if (int_out !== 6'h04) begin
            errors++; $display("FAIL second_edge_served: got int_out=%h, want 04", int_out);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 5) == 0) irq_src = irq_src ^ 6'($urandom);
            if ($urandom_range(0, 29) == 0) im = 6'($urandom);
            if ($urandom_range(0, 59) == 0) ie = ~ie;
            exl     = ($urandom_range(0, 19) == 0);
            ack     = ($urandom_range(0, 24) == 0);
            eoi     = ($urandom_range(0, 9) == 0);
            clr_err = ($urandom_range(0, 49) == 0);
            rst     = ($urandom_range(0, 399) != 0);
            tick();
            checks++;
            if (int_out !== m_int_out() || irq_id !== m_irq_id() || busy !== (m_cur >= 0) ||
                pending !== m_pend || timeout_err !== m_err) begin
                errors++;
                $display("FAIL random_cycle %0d: got int_out=%h id=%0d busy=%b pend=%h err=%b, want %h/%0d/%b/%h/%b",
                         c, int_out, irq_id, busy, pending, timeout_err,
                         m_int_out(), m_irq_id(), (m_cur >= 0), m_pend, m_err);
            end
        end
        rst = 1'b1; ack = 1'b0; eoi = 1'b0; clr_err = 1'b0; exl = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) hist[i] = 6'h00;
        test_reset();
        test_basic();
        test_priority();
        test_masking();
        test_timeout();
        test_exl_reset();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
